fb_port_arbiter: RTL

- Shares one single-port synchronous frame-buffer RAM between the VGA/HDMI scan-out read path and the UART image-loader write path.
- Scan-out reads are deadline-bound and always win. Loader writes are absorbed by a 4-entry write FIFO and drained into RAM on cycles with no scan-out read.
- Sits between the 1024x768 timing generator (pix_x/pix_y in, pix_data out) and the RS232 pixel assembler. The image is placed top-left; everything outside it shows a background colour.

---
 rtl/fb_port_arbiter_if.sv | 29 ++
 rtl/fb_port_arbiter.sv | 146 ++++++++++++++
 2 files changed

// File: rtl/fb_port_arbiter_if.sv
// Frame-buffer port bundle: scan-out request/response, loader write
// handshake and the single-port RAM interface.
interface fb_port_arbiter_if #(
  parameter int AW = 16
);
  logic [11:0]   pix_x;
  logic [11:0]   pix_y;
  logic [23:0]   pix_data;
  logic          wr_valid;
  logic          wr_ready;
  logic [AW-1:0] wr_addr;
  logic [23:0]   wr_data;
  logic [AW-1:0] ram_addr;
  logic          ram_we;
  logic [23:0]   ram_wdata;
  logic [23:0]   ram_rdata;

  // Environment side: timing generator, loader and RAM model.
  modport master (
    output pix_x, pix_y, wr_valid, wr_addr, wr_data, ram_rdata,
    input  pix_data, wr_ready, ram_addr, ram_we, ram_wdata
  );

  // Arbiter side.
  modport slave (
    input  pix_x, pix_y, wr_valid, wr_addr, wr_data, ram_rdata,
    output pix_data, wr_ready, ram_addr, ram_we, ram_wdata
  );
endinterface

// File: rtl/fb_port_arbiter.sv
// Frame-buffer port arbiter: scan-out reads always own the single RAM port;
// loader writes wait in a 4-entry FIFO and drain on cycles without a read.
module fb_port_arbiter #(
  parameter int          IMG_W_LOG2 = 8,
  parameter int          IMG_H_LOG2 = 8,
  parameter logic [23:0] BG_COLOR   = 24'h000000,
  parameter bit          BLANK_ONLY = 1'b0,
  parameter int          AW         = IMG_W_LOG2 + IMG_H_LOG2
) (
  input  logic                  vga_clk,
  input  logic                  sys_rst,
  fb_port_arbiter_if.slave      bus,
  output logic [2:0]            fifo_level,
  output logic [15:0]           stall_cnt
);

  localparam logic [11:0] NO_REQ = 12'hfff;
  localparam logic [12:0] IMG_W  = 13'd1 << IMG_W_LOG2;
  localparam logic [12:0] IMG_H  = 13'd1 << IMG_H_LOG2;

  // Read/drain decision
  logic          rd_hit_s;
  logic          drain_ok_s;
  logic          pop_s;
  logic          push_s;
  logic          fifo_empty_s;
  logic          fifo_full_s;
  logic [AW-1:0] rd_addr_s;
  logic [AW-1:0] head_addr_s;
  logic [23:0]   head_data_s;
  logic [AW-1:0] ram_addr_s;
  logic          ram_we_s;

  // State
  logic          hit_d_r;
  logic [AW-1:0] last_addr_r;
  logic [AW-1:0] fifo_addr_r [4];
  logic [23:0]   fifo_data_r [4];
  logic [1:0]    wr_ptr_r;
  logic [1:0]    rd_ptr_r;
  logic [2:0]    count_r;
  logic [15:0]   stall_r;

  // Classify the scan-out request and decide whether a drain may use the port.
  always_comb begin
    rd_hit_s     = (bus.pix_x != NO_REQ) && (bus.pix_y != NO_REQ) &&
                   ({1'b0, bus.pix_x} < IMG_W) && ({1'b0, bus.pix_y} < IMG_H);
    rd_addr_s    = {bus.pix_y[IMG_H_LOG2-1:0], bus.pix_x[IMG_W_LOG2-1:0]};
    drain_ok_s   = !rd_hit_s && ((BLANK_ONLY == 1'b0) || (bus.pix_x == NO_REQ));
    fifo_empty_s = (count_r == 3'd0);
    fifo_full_s  = (count_r == 3'd4);
    head_addr_s  = fifo_addr_r[rd_ptr_r];
    head_data_s  = fifo_data_r[rd_ptr_r];
    // Reset cycle never writes RAM, so entries in flight are simply dropped.
    pop_s        = !fifo_empty_s && drain_ok_s && !sys_rst;
    // Acceptance depends only on the registered count; a full FIFO refuses
    // even when it pops this cycle.
    push_s       = bus.wr_valid && !fifo_full_s && !sys_rst;
  end

  // Port select with fixed priority read > drain > idle; idle holds the address.
  always_comb begin
    ram_addr_s = last_addr_r;
    ram_we_s   = 1'b0;
    if (sys_rst) begin
      ram_addr_s = {AW{1'b0}};
      ram_we_s   = 1'b0;
    end else if (rd_hit_s) begin
      ram_addr_s = rd_addr_s;
      ram_we_s   = 1'b0;
    end else if (pop_s) begin
      ram_addr_s = head_addr_s;
      ram_we_s   = 1'b1;
    end else begin
      ram_addr_s = last_addr_r;
      ram_we_s   = 1'b0;
    end
  end

  // Drive the bus: RAM port, read-data mux and loader back-pressure.
  always_comb begin
    bus.ram_addr  = ram_addr_s;
    bus.ram_we    = ram_we_s;
    bus.ram_wdata = head_data_s;
    bus.wr_ready  = !fifo_full_s;
    fifo_level    = count_r;
    stall_cnt     = stall_r;
    if (hit_d_r) begin
      bus.pix_data = bus.ram_rdata;
    end else begin
      bus.pix_data = BG_COLOR;
    end
  end

  // Remember whether last cycle was an image read and the last RAM address.
  always_ff @(posedge vga_clk) begin
    if (sys_rst) begin
      hit_d_r     <= 1'b0;
      last_addr_r <= {AW{1'b0}};
    end else begin
      hit_d_r     <= rd_hit_s;
      last_addr_r <= ram_addr_s;
    end
  end

  // FIFO pointers and occupancy.
  always_ff @(posedge vga_clk) begin
    if (sys_rst) begin
      wr_ptr_r <= 2'd0;
      rd_ptr_r <= 2'd0;
      count_r  <= 3'd0;
    end else begin
      if (push_s) begin
        wr_ptr_r <= wr_ptr_r + 2'd1;
      end
      if (pop_s) begin
        rd_ptr_r <= rd_ptr_r + 2'd1;
      end
      case ({push_s, pop_s})
        2'b10:   count_r <= count_r + 3'd1;
        2'b01:   count_r <= count_r - 3'd1;
        default: count_r <= count_r;
      endcase
    end
  end

  // FIFO storage; contents are only meaningful below the occupancy count.
  always_ff @(posedge vga_clk) begin
    if (push_s) begin
      fifo_addr_r[wr_ptr_r] <= bus.wr_addr;
      fifo_data_r[wr_ptr_r] <= bus.wr_data;
    end
  end

  // Count cycles where pending writes were locked out of the RAM port.
  always_ff @(posedge vga_clk) begin
    if (sys_rst) begin
      stall_r <= 16'd0;
    end else if (!fifo_empty_s && !drain_ok_s && (stall_r != 16'hffff)) begin
      stall_r <= stall_r + 16'd1;
    end else begin
      stall_r <= stall_r;
    end
  end

endmodule
